multi_signal_generator: RTL and testbench

Parametrised multi-channel periodic signal generator, the successor to the single-output `SignalGenerator`. Each of `NCH` independent channels produces a programmable-period, programmable-high-time waveform in continuous or one-shot mode. Channel configuration is double-buffered, so reconfiguration never glitches a running period. A global sync input phase-aligns all channels. The block sits in the system clock domain and drives timing/strobe outputs for downstream logic.

---
 rtl/multi_signal_generator.sv | 113 +++++++++++
 tb/tb_multi_signal_generator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_signal_generator.sv
// Multi-channel periodic waveform generator with double-buffered per-channel
// configuration, continuous/one-shot modes and a global phase-align sync.
module msg_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period_m1,
    input  logic [CNT_W-1:0] high,
    input  logic             sync_in,
    output logic             signal_out,
    output logic             period_end,
    output logic             busy
);
    localparam logic [1:0] MODE_CONT = 2'd1;
    localparam logic [1:0] MODE_ONE  = 2'd2;

    logic [1:0]       p_mode, a_mode;
    logic [CNT_W-1:0] p_period, a_period, p_high, a_high, cnt;
    logic             dirty, run;
    logic             at_end, apply, p_start;
    logic [CNT_W:0]   cnt_inc;

    assign at_end  = run && (cnt == a_period);
    // Pending config moves to active only when it cannot cut a period short.
    assign apply   = dirty && (!run || sync_in || at_end);
    assign p_start = (p_mode == MODE_CONT) || (p_mode == MODE_ONE);
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign busy    = run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_mode     <= '0;
            p_period   <= '0;
            p_high     <= '0;
            a_mode     <= '0;
            a_period   <= '0;
            a_high     <= '0;
            cnt        <= '0;
            dirty      <= 1'b0;
            run        <= 1'b0;
            signal_out <= 1'b0;
            period_end <= 1'b0;
        end else begin
            period_end <= at_end && !sync_in;
            // A write on the apply edge re-arms dirty so it lands next time.
            if (we) begin
                p_mode   <= mode;
                p_period <= period_m1;
                p_high   <= high;
                dirty    <= 1'b1;
            end else if (apply) begin
                dirty    <= 1'b0;
            end

            if (apply) begin
                a_mode     <= p_mode;
                a_period   <= p_period;
                a_high     <= p_high;
                cnt        <= '0;
                run        <= p_start;
                signal_out <= p_start && (p_high != '0);
            end else if (run) begin
                if (sync_in || (at_end && a_mode == MODE_CONT)) begin
                    cnt        <= '0;
                    signal_out <= (a_high != '0);
                end else if (at_end) begin
                    run        <= 1'b0;
                    signal_out <= 1'b0;
                end else begin
                    cnt        <= cnt_inc[CNT_W-1:0];
                    signal_out <= (cnt_inc < {1'b0, a_high});
                end
            end
        end
    end
endmodule

module multi_signal_generator #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period_m1,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             sync_in,
    output logic [NCH-1:0]   signal_out,
    output logic [NCH-1:0]   period_end,
    output logic [NCH-1:0]   busy
);
    // Out-of-range channel selects match no instance and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        msg_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .we         (cfg_we && (cfg_ch == CH_W'(i))),
            .mode       (cfg_mode),
            .period_m1  (cfg_period_m1),
            .high       (cfg_high),
            .sync_in    (sync_in),
            .signal_out (signal_out[i]),
            .period_end (period_end[i]),
            .busy       (busy[i])
        );
    end
endmodule

// File: tb/tb_multi_signal_generator.sv
// Bench for multi_signal_generator: directed waveform scenarios plus random
// traffic checked against a per-channel phase/run model.
module tb_multi_signal_generator;
    localparam int NCH   = 5;
    localparam int CNT_W = 8;
    localparam int CH_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CNT_W-1:0] cfg_period_m1 = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             sync_in = 1'b0;
    logic [NCH-1:0]   signal_out, period_end, busy;

    int total = 0;
    int bad = 0;

    // Model: pending/active config, phase within period, running flag.
    int m_pmode[NCH], m_pper[NCH], m_phigh[NCH], m_dirty[NCH];
    int m_amode[NCH], m_aper[NCH], m_ahigh[NCH];
    int m_pos[NCH], m_run[NCH], m_pe[NCH];

    multi_signal_generator #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period_m1(cfg_period_m1),
        .cfg_high(cfg_high), .sync_in(sync_in), .signal_out(signal_out),
        .period_end(period_end), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pmode[c] = 0; m_pper[c] = 0; m_phigh[c] = 0; m_dirty[c] = 0;
            m_amode[c] = 0; m_aper[c] = 0; m_ahigh[c] = 0;
            m_pos[c] = 0; m_run[c] = 0; m_pe[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit wr, last, app;
            wr   = cfg_we && (int'(cfg_ch) == c);
            last = m_run[c] != 0 && m_pos[c] == m_aper[c];
            app  = m_dirty[c] != 0 && (m_run[c] == 0 || sync_in || last);
            m_pe[c] = (last && !sync_in) ? 1 : 0;
            if (app) begin
                m_amode[c] = m_pmode[c]; m_aper[c] = m_pper[c]; m_ahigh[c] = m_phigh[c];
                m_pos[c] = 0;
                m_run[c] = (m_pmode[c] == 1 || m_pmode[c] == 2) ? 1 : 0;
            end else if (m_run[c] != 0) begin
                if (sync_in) m_pos[c] = 0;
                else if (last) begin
                    if (m_amode[c] == 1) m_pos[c] = 0;
                    else m_run[c] = 0;
                end else m_pos[c]++;
            end
            if (wr) begin
                m_pmode[c] = int'(cfg_mode); m_pper[c] = int'(cfg_period_m1);
                m_phigh[c] = int'(cfg_high); m_dirty[c] = 1;
            end else if (app) m_dirty[c] = 0;
        end
    endtask

    task automatic model_check();
        logic [31:0] es, ep, eb;
        es = '0; ep = '0; eb = '0;
        for (int c = 0; c < NCH; c++) begin
            es[c] = (m_run[c] != 0 && m_pos[c] < m_ahigh[c]);
            ep[c] = (m_pe[c] != 0);
            eb[c] = (m_run[c] != 0);
        end
        chk("signal_out", 32'(signal_out), es);
        chk("period_end", 32'(period_end), ep);
        chk("busy", 32'(busy), eb);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
        cfg_we = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic set_wr(input int ch, input int mode, input int per, input int hi);
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_period_m1 = CNT_W'(per);
        cfg_high = CNT_W'(hi);
    endtask

    initial begin
        logic [9:0] pat;
        logic [4:0] ps, pb;
        int npe;
        model_reset();
        #1;
        chk("reset_sig", 32'(signal_out), 0);
        chk("reset_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_after_reset", 32'(busy), 0);

        // Continuous P=5/H=2
        set_wr(0, 1, 4, 2); step();
        pat = '0;
        for (int i = 0; i < 10; i++) begin step(); pat = {pat[8:0], signal_out[0]}; end
        chk("cont_pattern", 32'(pat), 32'b1100011000);

        // Reconfig high=4 mid-period: current period finishes unchanged
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) set_wr(0, 1, 4, 4);
            step(); pat = {pat[8:0], signal_out[0]};
        end
        chk("reconfig_pattern", 32'(pat), 32'b1100011110);

        // Write on the boundary edge lands one period later
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) set_wr(0, 1, 4, 1);
            step(); pat = {pat[8:0], signal_out[0]};
        end
        chk("boundary_write_pattern", 32'(pat), 32'b1111010000);

        // One-shot P=3/H=3
        set_wr(1, 2, 2, 3); step();
        npe = 0;
        for (int i = 0; i < 5; i++) begin
            step(); ps[4-i] = signal_out[1]; pb[4-i] = busy[1]; npe += int'(period_end[1]);
        end
        chk("oneshot_sig", 32'(ps), 32'b11100);
        chk("oneshot_busy", 32'(pb), 32'b11100);
        chk("oneshot_pe_count", 32'(npe), 1);

        // Sync alignment of ch0 and ch2
        set_wr(0, 0, 0, 0); repeat (7) step();
        set_wr(0, 1, 7, 4); step(); step(); step();
        set_wr(2, 1, 7, 4); step(); step(); step();
        sync_in = 1'b1; step();
        chk("sync_pe_suppressed", 32'({period_end[2], period_end[0]}), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("sync_aligned", 32'(signal_out[2]), 32'(signal_out[0]));
        end

        // Degenerate values and out-of-range channel
        set_wr(3, 1, 4, 0); step();
        set_wr(4, 1, 4, 9); step();
        set_wr(1, 1, 0, 1); step();
        set_wr(5, 1, 3, 1); step();
        set_wr(7, 2, 2, 2); step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("deg_h0", 32'(signal_out[3]), 0);
            chk("deg_hbig", 32'(signal_out[4]), 1);
            chk("deg_p1", 32'({period_end[1], signal_out[1]}), 3);
        end

        // Asynchronous reset mid-period
        #2 rst = 1'b1;
        #1;
        chk("rst_async_sig", 32'(signal_out), 0);
        chk("rst_async_pe", 32'(period_end), 0);
        chk("rst_async_busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step();
        chk("idle_after_midreset", 32'(busy), 0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(2) == 0)
                set_wr($urandom_range(7), $urandom_range(3), $urandom_range(7), $urandom_range(9));
            if ($urandom_range(24) == 0) sync_in = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
